gain_ramp_ctrl: RTL and testbench
=================================

Name: gain_ramp_ctrl

Overview:
- Anti-zipper gain controller that owns and sequences the shared `attenuator` datapath.
- Accepts a host gain target and a mute request, and slews the attenuator multiplier toward the target by a programmable step once per audio sample.
- Registers the attenuated sample.
- Sits between the control/UI register block and the audio output stage, so that gain changes and mute never produce clicks.

Parameters:
- DWIDTH, 16, sample width, two's complement.
- MULT_W, 9, multiplier width; unity gain UNITY = 1<<(MULT_W-1) = 256.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- data_i  input  DWIDTH  signed input sample.
- data_valid_i  input  1  one-cycle strobe per audio sample; also acts as the ramp tick.
- target_i  input  MULT_W  requested gain; values above UNITY are clamped to UNITY.
- target_valid_i  input  1  load strobe for target_i.
- step_i  input  MULT_W  ramp increment per sample; 0 = instant jump.
- mute_i  input  1  level; high requests fade to silence.
- data_o  output  DWIDTH  attenuated sample, registered.
- data_valid_o  output  1  strobe for data_o.
- mult_o  output  MULT_W  current gain (cur_r) applied to the datapath.
- ramping_o  output  1  cur_r differs from the current goal.
- muted_o  output  1  state == MUTED.

Behaviour:
- Clock/reset: one clock (clk_i); reset is asynchronous and active-low (rst_n_i).
- Reset values:
  - cur_r = 0, tgt_r = 0, state = TRACK.
  - data_o = 0, data_valid_o = 0, ramping_o = 0, muted_o = 0.
  - Output is silent until the host loads a target.
- Target register:
  - On target_valid_i, tgt_r <= min(target_i, UNITY), in any state.
  - While muted, the target is stored and applied after unmute.
- Goal: 0 in FADE_OUT and MUTED; tgt_r in TRACK.
- Ramp update (only in a cycle with data_valid_i):
  - If step_i = 0: cur_r <= goal.
  - Else if cur_r < goal: cur_r <= min(cur_r + step_i, goal). Compute at MULT_W+1 bits; no wrap.
  - Else if cur_r > goal: cur_r <= max(cur_r - step_i, goal). No underflow.
  - Never overshoot; cur_r lands exactly on goal.
- Datapath:
  - The sample in a valid cycle is attenuated with the pre-update cur_r.
  - data_o <= attenuator(data_i, cur_r); data_valid_o <= data_valid_i. Latency is exactly 1 cycle.
  - data_o holds its value when no valid is present.
- State machine (mute_i sampled every clock, independent of data_valid_i):
  - TRACK: mute_i = 1 -> FADE_OUT.
  - FADE_OUT: mute_i = 0 -> TRACK (ramps back up from the current cur_r). Otherwise cur_r == 0 -> MUTED. This also means a mute issued while cur_r is already 0 reaches MUTED one clock later.
  - MUTED: cur_r held at 0. mute_i = 0 -> TRACK, which then ramps up to tgt_r.
- Simultaneous events:
  - target_valid_i with data_valid_i: that tick ramps toward the old tgt_r; the new target applies from the next tick.
  - mute_i change with data_valid_i: that tick uses the goal of the current (pre-transition) state.
- ramping_o = (cur_r != goal), combinational from registers.
- Reset mid-ramp: all registers return to reset values immediately (asynchronous); any in-flight data_valid_o is dropped.
- Attenuator arithmetic is inherited, including its ones'-complement sign behaviour: a negative input with gain 0 yields 0xFFFF, not 0x0000. This is accepted as -1 LSB.

Decomposition:
- Shared package audio_pkg holds:
  - the UNITY constant function of MULT_W;
  - enum ramp_state_t {TRACK, FADE_OUT, MUTED}.
- Sub-module: instantiate the existing `attenuator` (DWIDTH, MULT_W) combinationally on data_i/cur_r, and register its output in this block.
- The ramp arithmetic stays in-line; no further hierarchy.

Test Plan:
- Reset, then tgt = 256, step = 16, 20 valid samples of 0x4000: mult_o goes 0, 16, …, 256 over 16 samples then holds. ramping_o clears on the cycle cur_r = 256. The last data_o = 0x4000 and data_valid_o lags one cycle.
- cur = 0, tgt = 250, step = 100: mult_o goes 100, 200, 250 with no overshoot. Then target_i = 300 is loaded and clamps to 256 on the next tick.
- Gain 128, inputs 0x4000 and 0xC000: data_o = 0x2000 and 0xE000. Gain 0 with input 0xC000 gives 0xFFFF.
- At cur = 192, assert mute with step = 64: cur goes 128, 64, 0, then muted_o = 1. Load tgt = 64 while muted and release mute: cur ramps to 64.
- Deassert mute in FADE_OUT at cur = 128: state returns to TRACK and ramps up to tgt_r without reaching MUTED. Also: step = 0 with tgt = 200 jumps on a single tick.
- Assert rst_n_i low mid-ramp, between clock edges: mult_o, data_o, data_valid_o, muted_o and ramping_o go to 0 immediately.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio constants and the gain-ramp state type.
package audio_pkg;

    typedef enum logic [1:0] {
        TRACK,
        FADE_OUT,
        MUTED
    } ramp_state_t;

    // Unity gain for a multiplier of the given width (MSB alone set).
    function automatic int unsigned unity(input int unsigned mult_w);
        return 32'd1 << (mult_w - 1);
    endfunction

endpackage

// File: rtl/attenuator.sv
// attenuator: combinational sample scaler, out = in * mult / UNITY using ones'-complement magnitude for negatives.
module attenuator #(
    parameter int DWIDTH = 16,
    parameter int MULT_W = 9
) (
    input  logic [DWIDTH-1:0] i_data,
    input  logic [MULT_W-1:0] i_mult,
    output logic [DWIDTH-1:0] o_data
);

    localparam int PW = DWIDTH + MULT_W;

    logic              w_neg;
    logic [DWIDTH-1:0] w_mag;
    logic [PW-1:0]     w_prod;
    logic [DWIDTH-1:0] w_scaled;

    // Negative samples are scaled as their ones' complement and inverted back,
    // so a negative input at gain 0 comes out as all ones (-1 LSB).
    assign w_neg    = i_data[DWIDTH-1];
    assign w_mag    = w_neg ? ~i_data : i_data;
    assign w_prod   = PW'(w_mag) * PW'(i_mult);
    assign w_scaled = DWIDTH'(w_prod >> (MULT_W - 1));
    assign o_data   = w_neg ? ~w_scaled : w_scaled;

endmodule

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: anti-zipper gain slew and mute sequencing around the attenuator datapath.
module gain_ramp_ctrl
    import audio_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int MULT_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              data_valid_i,
    input  logic [MULT_W-1:0] target_i,
    input  logic              target_valid_i,
    input  logic [MULT_W-1:0] step_i,
    input  logic              mute_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              data_valid_o,
    output logic [MULT_W-1:0] mult_o,
    output logic              ramping_o,
    output logic              muted_o
);

    localparam logic [MULT_W-1:0] UNITY = MULT_W'(unity(MULT_W));

    ramp_state_t       r_state;
    ramp_state_t       w_state_next;
    logic [MULT_W-1:0] r_cur;
    logic [MULT_W-1:0] r_tgt;
    logic [MULT_W-1:0] w_goal;
    logic [MULT_W-1:0] w_up_gap;
    logic [MULT_W-1:0] w_dn_gap;
    logic [MULT_W-1:0] w_cur_next;
    logic [MULT_W-1:0] w_tgt_clamped;
    logic [DWIDTH-1:0] r_data;
    logic [DWIDTH-1:0] w_att;
    logic              r_dv;

    attenuator #(
        .DWIDTH(DWIDTH),
        .MULT_W(MULT_W)
    ) u_att (
        .i_data(data_i),
        .i_mult(r_cur),
        .o_data(w_att)
    );

    assign w_goal        = (r_state == TRACK) ? r_tgt : '0;
    assign w_tgt_clamped = (target_i > UNITY) ? UNITY : target_i;
    assign w_up_gap      = w_goal - r_cur;
    assign w_dn_gap      = r_cur - w_goal;

    // Next gain: step toward the goal, landing exactly on it once within one step.
    always_comb begin
        w_cur_next = (step_i == '0)    ? w_goal :
                     (r_cur < w_goal)  ? ((w_up_gap > step_i) ? r_cur + step_i : w_goal) :
                     (r_cur > w_goal)  ? ((w_dn_gap > step_i) ? r_cur - step_i : w_goal) :
                                         r_cur;
    end

    // Mute sequencing: fade to zero before declaring muted; unmute resumes tracking.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TRACK:    w_state_next = mute_i ? FADE_OUT : TRACK;
            FADE_OUT: w_state_next = !mute_i ? TRACK : (r_cur == '0) ? MUTED : FADE_OUT;
            MUTED:    w_state_next = mute_i ? MUTED : TRACK;
            default:  w_state_next = TRACK;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= TRACK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Gain advances only on sample ticks; target loads whenever strobed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cur <= '0;
            r_tgt <= '0;
        end else begin
            if (data_valid_i) r_cur <= w_cur_next;
            if (target_valid_i) r_tgt <= w_tgt_clamped;
        end
    end

    // Output sample register, scaled with the gain in force before this tick.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
            r_dv   <= 1'b0;
        end else begin
            r_dv <= data_valid_i;
            if (data_valid_i) r_data <= w_att;
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_dv;
    assign mult_o       = r_cur;
    assign ramping_o    = (r_cur != w_goal);
    assign muted_o      = (r_state == MUTED);

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// tb_gain_ramp_ctrl: directed and randomized checks of gain_ramp_ctrl against an arithmetic reference model.
module tb_gain_ramp_ctrl;

    localparam int M_TRACK = 0;
    localparam int M_FADE  = 1;
    localparam int M_MUTED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic        dv_i = 1'b0;
    logic [8:0]  tgt_i = '0;
    logic        tv_i = 1'b0;
    logic [8:0]  step_i = '0;
    logic        mute_i = 1'b0;
    logic [15:0] data_o;
    logic        dv_o;
    logic [8:0]  mult_o;
    logic        ramping_o;
    logic        muted_o;

    int checks = 0;
    int failures = 0;
    int m_cur, m_tgt, m_mode, m_dout, m_dv;

    always #5 clk = ~clk;

    gain_ramp_ctrl #(.DWIDTH(16), .MULT_W(9)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .data_i(data_i),
        .data_valid_i(dv_i),
        .target_i(tgt_i),
        .target_valid_i(tv_i),
        .step_i(step_i),
        .mute_i(mute_i),
        .data_o(data_o),
        .data_valid_o(dv_o),
        .mult_o(mult_o),
        .ramping_o(ramping_o),
        .muted_o(muted_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scaling rule: x*g/256 for x >= 0; negatives use ones'-complement magnitude.
    function automatic int m_att(input logic [15:0] x, input int g);
        int xi;
        xi = int'($signed(x));
        if (xi >= 0) return (xi * g) / 256;
        return -(((-xi - 1) * g) / 256) - 1;
    endfunction

    function automatic int m_goal();
        return (m_mode == M_TRACK) ? m_tgt : 0;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_mode = M_TRACK; m_dout = 0; m_dv = 0;
    endtask

    task automatic model_clock();
        int g, nc, nm;
        g = m_goal();
        nc = m_cur;
        nm = m_mode;
        if (dv_i) begin
            m_dout = m_att(data_i, m_cur) & 16'hFFFF;
            if (step_i == 0) nc = g;
            else if (m_cur < g) nc = (m_cur + int'(step_i) > g) ? g : m_cur + int'(step_i);
            else if (m_cur > g) nc = (m_cur - int'(step_i) < g) ? g : m_cur - int'(step_i);
        end
        m_dv = dv_i;
        if (tv_i) m_tgt = (tgt_i > 256) ? 256 : int'(tgt_i);
        if (m_mode == M_TRACK) nm = mute_i ? M_FADE : M_TRACK;
        else if (m_mode == M_FADE) nm = !mute_i ? M_TRACK : (m_cur == 0) ? M_MUTED : M_FADE;
        else nm = mute_i ? M_MUTED : M_TRACK;
        m_cur = nc;
        m_mode = nm;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mult"}, 32'(mult_o), m_cur);
        chk({tag, ".ramping"}, 32'(ramping_o), 32'(m_cur != m_goal()));
        chk({tag, ".muted"}, 32'(muted_o), 32'(m_mode == M_MUTED));
        chk({tag, ".dv"}, 32'(dv_o), m_dv);
        chk({tag, ".data"}, 32'(data_o), m_dout);
    endtask

    task automatic tick(input string tag, input logic dv, input logic [15:0] d, input logic tv,
                        input logic [8:0] t, input logic [8:0] s, input logic m);
        dv_i = dv; data_i = d; tv_i = tv; tgt_i = t; step_i = s; mute_i = m;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        tick("load256", 0, 0, 1, 256, 16, 0);
        for (int i = 0; i < 20; i++) tick("ramp16", 1, 16'h4000, 0, 0, 16, 0);
        chk("ramp_full", 32'(mult_o), 256);
        chk("ramp_last_data", 32'(data_o), 32'h4000);
        tick("idle", 0, 16'h1234, 0, 0, 16, 0);
        chk("hold_data", 32'(data_o), 32'h4000);
        chk("dv_drop", 32'(dv_o), 0);

        tick("load0", 0, 0, 1, 0, 0, 0);
        tick("jump0", 1, 0, 0, 0, 0, 0);
        tick("load250", 0, 0, 1, 250, 100, 0);
        tick("s100a", 1, 0, 0, 0, 100, 0);
        chk("s100_1", 32'(mult_o), 100);
        tick("s100b", 1, 0, 0, 0, 100, 0);
        chk("s100_2", 32'(mult_o), 200);
        tick("s100c", 1, 0, 0, 0, 100, 0);
        chk("s100_3", 32'(mult_o), 250);
        tick("load300", 0, 0, 1, 300, 100, 0);
        tick("clamp", 1, 0, 0, 0, 100, 0);
        chk("clamp256", 32'(mult_o), 256);

        tick("load128", 0, 0, 1, 128, 0, 0);
        tick("jump128", 1, 0, 0, 0, 0, 0);
        tick("att_pos", 1, 16'h4000, 0, 0, 0, 0);
        chk("att_pos_k", 32'(data_o), 32'h2000);
        tick("att_neg", 1, 16'hC000, 0, 0, 0, 0);
        chk("att_neg_k", 32'(data_o), 32'hE000);
        tick("load_g0", 0, 0, 1, 0, 0, 0);
        tick("jump_g0", 1, 16'h7FFF, 0, 0, 0, 0);
        tick("att_zero", 1, 16'hC000, 0, 0, 0, 0);
        chk("att_zero_k", 32'(data_o), 32'hFFFF);

        tick("load192", 0, 0, 1, 192, 0, 0);
        tick("jump192", 1, 0, 0, 0, 0, 0);
        tick("mute_on", 0, 0, 0, 0, 64, 1);
        tick("fade1", 1, 16'h1000, 0, 0, 64, 1);
        chk("fade_128", 32'(mult_o), 128);
        tick("fade2", 1, 16'h1000, 0, 0, 64, 1);
        tick("fade3", 1, 16'h1000, 0, 0, 64, 1);
        chk("fade_0", 32'(mult_o), 0);
        tick("to_muted", 0, 0, 0, 0, 64, 1);
        chk("muted_k", 32'(muted_o), 1);
        tick("muted_load", 1, 16'h2000, 1, 64, 64, 1);
        chk("muted_hold0", 32'(mult_o), 0);
        tick("unmute", 0, 0, 0, 0, 64, 0);
        tick("rampup64", 1, 0, 0, 0, 64, 0);
        chk("up64", 32'(mult_o), 64);

        tick("load192b", 0, 0, 1, 192, 0, 0);
        tick("jump192b", 1, 0, 0, 0, 0, 0);
        tick("mute_on2", 0, 0, 0, 0, 64, 1);
        tick("fade_b", 1, 0, 0, 0, 64, 1);
        tick("unmute_fade", 0, 0, 0, 0, 64, 0);
        chk("unmute_not_muted", 32'(muted_o), 0);
        chk("unmute_ramping", 32'(ramping_o), 1);
        tick("reramp", 1, 0, 0, 0, 64, 0);
        chk("reramp192", 32'(mult_o), 192);

        tick("load200", 0, 0, 1, 200, 0, 0);
        tick("jump200", 1, 0, 0, 0, 0, 0);
        chk("jump200_k", 32'(mult_o), 200);

        tick("load_dn", 0, 0, 1, 0, 8, 0);
        tick("mid_ramp", 1, 16'h4000, 0, 0, 8, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mult", 32'(mult_o), 0);
        chk("arst_data", 32'(data_o), 0);
        chk("arst_dv", 32'(dv_o), 0);
        chk("arst_muted", 32'(muted_o), 0);
        chk("arst_ramping", 32'(ramping_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all("post_rst");

        begin
            logic m;
            m = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) m = ~m;
                tick("rand", ($urandom_range(0, 2) != 0), 16'($urandom),
                     ($urandom_range(0, 9) == 0), 9'($urandom_range(0, 511)),
                     ($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom_range(1, 40)), m);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
